// File: rtl/ioport_bank.sv
// Bank of NPORTS latched Z80 I/O write registers with prioritised address/mask decode,
// once-per-bus-cycle commit and per-channel write lock; read-back under IOPORT_READBACK_EN.
module ioport_bank #(
  parameter int                   NPORTS    = 4,
  parameter int                   DW        = 8,
  parameter logic [16*NPORTS-1:0] PORT_ADDR = {16'h7FFD, 16'hDFFD, 16'h1FFD, 16'h00FE},
  parameter logic [16*NPORTS-1:0] PORT_MASK = {16'h8002, 16'hFFFF, 16'hF002, 16'h0001},
  parameter logic [NPORTS*DW-1:0] RESET_VAL = '0,
  parameter logic [NPORTS-1:0]    LOCKABLE  = 4'b1000,
  parameter int                   LOCK_BIT  = 5
) (
  input  logic                 clk28,
  input  logic                 rst,
  input  logic                 ioreq,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [15:0]          a,
  input  logic [7:0]           d_in,
  input  logic [NPORTS-1:0]    en,
  input  logic                 unlock,
  output logic [NPORTS*DW-1:0] regs,
  output logic [NPORTS-1:0]    wr_stb,
  output logic [NPORTS-1:0]    locked,
  output logic [7:0]           d_out,
  output logic                 d_out_active,
  output logic                 dbg_armed
);

  typedef enum logic {ARMED, DONE} state_t;

  state_t                state_q;
  logic [NPORTS*DW-1:0]  regs_q;
  logic [NPORTS-1:0]     wr_stb_q;
  logic [NPORTS-1:0]     locked_q;
  logic [NPORTS-1:0]     hit;
  logic [NPORTS-1:0]     sel_oh;
  logic                  sel_any;
  logic                  blocked;
  logic                  found;
  logic                  bus_wr;

  assign bus_wr = ioreq && wr;

  // Lowest-index hit wins; sel_oh is one-hot (or zero when nothing decodes).
  always_comb begin
    hit    = '0;
    sel_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      hit[i] = en[i] && (((a ^ PORT_ADDR[16*i +: 16]) & PORT_MASK[16*i +: 16]) == 16'h0000);
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (hit[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign sel_any = |hit;
  assign blocked = (|(sel_oh & LOCKABLE & locked_q)) && !unlock;

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q  <= ARMED;
      regs_q   <= RESET_VAL;
      wr_stb_q <= '0;
      locked_q <= '0;
    end else begin
      wr_stb_q <= '0;
      case (state_q)
        ARMED: begin
          if (bus_wr) begin
            state_q <= DONE;
            if (sel_any && !blocked) begin
              for (int i = 0; i < NPORTS; i++) begin
                if (sel_oh[i]) begin
                  regs_q[DW*i +: DW] <= d_in[DW-1:0];
                  wr_stb_q[i]        <= 1'b1;
                  if (LOCKABLE[i]) locked_q[i] <= d_in[LOCK_BIT];
                end
              end
            end
          end
        end
        DONE: begin
          // Stay here until the bus write cycle ends, so one cycle commits once.
          if (!bus_wr) state_q <= ARMED;
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign regs      = regs_q;
  assign wr_stb    = wr_stb_q;
  assign locked    = locked_q;
  assign dbg_armed = (state_q == ARMED);

`ifdef IOPORT_READBACK_EN
  logic [7:0] rd_data;
  logic [7:0] d_out_q;
  logic       d_out_active_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel_oh[i]) rd_data[DW-1:0] = rd_data[DW-1:0] | regs_q[DW*i +: DW];
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      d_out_active_q <= 1'b0;
      d_out_q        <= 8'hFF;
    end else if (ioreq && rd && !wr && sel_any) begin
      d_out_active_q <= 1'b1;
      d_out_q        <= rd_data;
    end else begin
      d_out_active_q <= 1'b0;
      d_out_q        <= 8'hFF;
    end
  end

  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;
`else
  logic unused_rd;
  assign unused_rd    = rd;
  assign d_out        = 8'hFF;
  assign d_out_active = 1'b0;
`endif

endmodule

// File: tb/tb_ioport_bank.sv
// Directed self-checking bench for ioport_bank (default parameters, 4 channels x 8 bits).
module tb_ioport_bank;

  logic        clk28 = 1'b0;
  logic        rst = 1'b1;
  logic        ioreq = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic [3:0]  en = 4'hF;
  logic        unlock = 1'b0;
  logic [31:0] regs;
  logic [3:0]  wr_stb;
  logic [3:0]  locked;
  logic [7:0]  d_out;
  logic        d_out_active;
  logic        dbg_armed;

  int          n_compared = 0;
  int          n_mismatched = 0;
  int          stb_cnt;
  logic [3:0]  stb_or;

  ioport_bank dut (
    .clk28(clk28), .rst(rst), .ioreq(ioreq), .rd(rd), .wr(wr), .a(a), .d_in(d_in),
    .en(en), .unlock(unlock), .regs(regs), .wr_stb(wr_stb), .locked(locked),
    .d_out(d_out), .d_out_active(d_out_active), .dbg_armed(dbg_armed)
  );

  always #5 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds ioreq&wr for n cycles, then releases for one cycle; tallies strobes seen.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int n);
    a = addr; d_in = data; ioreq = 1'b1; wr = 1'b1;
    stb_cnt = 0; stb_or = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      stb_cnt += $countones(wr_stb);
      stb_or  |= wr_stb;
    end
    ioreq = 1'b0; wr = 1'b0;
    tick();
    stb_cnt += $countones(wr_stb);
    stb_or  |= wr_stb;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_regs", regs, 32'h0000_0000);
    check("rst_locked", {28'd0, locked}, 32'd0);
    check("rst_wr_stb", {28'd0, wr_stb}, 32'd0);
    check("rst_d_out", {24'd0, d_out}, 32'h0000_00FF);
    check("rst_d_out_active", {31'd0, d_out_active}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_armed", {31'd0, dbg_armed}, 32'd1);

    // 1: write 7FFD=17 held 6 cycles, check 1-cycle latency and single strobe
    a = 16'h7FFD; d_in = 8'h17; ioreq = 1'b1; wr = 1'b1;
    tick();
    check("t1_regs_latency", regs, 32'h1700_0000);
    check("t1_stb_first", {28'd0, wr_stb}, 32'h8);
    check("t1_done_state", {31'd0, dbg_armed}, 32'd0);
    stb_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      stb_cnt += $countones(wr_stb);
    end
    ioreq = 1'b0; wr = 1'b0;
    tick();
    stb_cnt += $countones(wr_stb);
    check("t1_no_extra_stb", stb_cnt, 32'd0);
    check("t1_locked", {28'd0, locked}, 32'd0);
    check("t1_rearmed", {31'd0, dbg_armed}, 32'd1);

    // 2: lock channel 3, blocked write, then unlock override
    bus_write(16'h7FFD, 8'h20, 3);
    check("t2_lock_regs", regs, 32'h2000_0000);
    check("t2_lock_locked", {28'd0, locked}, 32'h8);
    check("t2_lock_stb", stb_cnt, 32'd1);
    bus_write(16'h7FFD, 8'h05, 3);
    check("t2_blocked_regs", regs, 32'h2000_0000);
    check("t2_blocked_stb", stb_cnt, 32'd0);
    check("t2_blocked_locked", {28'd0, locked}, 32'h8);
    unlock = 1'b1;
    bus_write(16'h7FFD, 8'h05, 3);
    unlock = 1'b0;
    check("t2_unlock_regs", regs, 32'h0500_0000);
    check("t2_unlock_locked", {28'd0, locked}, 32'd0);
    check("t2_unlock_stb", {28'd0, stb_or}, 32'h8);

    // 3: 10-cycle write at DFFD with data changing mid-cycle
    a = 16'hDFFD; d_in = 8'h03; ioreq = 1'b1; wr = 1'b1;
    stb_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      stb_cnt += $countones(wr_stb);
      if (k == 3) d_in = 8'h07;
    end
    ioreq = 1'b0; wr = 1'b0;
    tick();
    stb_cnt += $countones(wr_stb);
    check("t3_regs", regs, 32'h0503_0000);
    check("t3_one_stb", stb_cnt, 32'd1);

    // 4: overlapping decode, lowest channel wins
    bus_write(16'h1FFC, 8'h44, 2);
    check("t4_regs", regs, 32'h0503_0044);
    check("t4_stb", {28'd0, stb_or}, 32'h1);

    // No-hit address
    bus_write(16'h8001, 8'hFF, 2);
    check("nohit_regs", regs, 32'h0503_0044);
    check("nohit_stb", stb_cnt, 32'd0);
    check("nohit_armed", {31'd0, dbg_armed}, 32'd1);

    // 5: decode disabled by en, then read-back
    en = 4'b1011;
    bus_write(16'hDFFD, 8'h11, 2);
    check("t5_en_regs", regs, 32'h0503_0044);
    check("t5_en_stb", stb_cnt, 32'd0);
    en = 4'hF;
    bus_write(16'hDFFD, 8'h04, 2);
    check("t5_wr04_regs", regs, 32'h0504_0044);
    a = 16'hDFFD; ioreq = 1'b1; rd = 1'b1;
    #1;
    check("t5_rd_pre_active", {31'd0, d_out_active}, 32'd0);
    tick();
`ifdef IOPORT_READBACK_EN
    check("t5_rd_d_out", {24'd0, d_out}, 32'h04);
    check("t5_rd_active", {31'd0, d_out_active}, 32'd1);
    tick();
    check("t5_rd_hold", {23'd0, d_out_active, d_out}, 32'h104);
`else
    check("t5_rd_d_out", {24'd0, d_out}, 32'hFF);
    check("t5_rd_active", {31'd0, d_out_active}, 32'd0);
    tick();
`endif
    ioreq = 1'b0; rd = 1'b0;
    tick();
    check("t5_rd_drop", {23'd0, d_out_active, d_out}, 32'h0FF);
    // rd and wr together behave as a write, read path stays idle
    a = 16'hDFFD; d_in = 8'h09; ioreq = 1'b1; rd = 1'b1; wr = 1'b1;
    tick();
    check("t5_rdwr_stb", {28'd0, wr_stb}, 32'h4);
    check("t5_rdwr_active", {31'd0, d_out_active}, 32'd0);
    check("t5_rdwr_regs", regs, 32'h0509_0044);
    ioreq = 1'b0; rd = 1'b0; wr = 1'b0;
    tick();

    // 6: reset in the middle of a write, then commit once after release
    bus_write(16'h7FFD, 8'h20, 2);
    check("t6_pre_locked", {28'd0, locked}, 32'h8);
    a = 16'h00FE; d_in = 8'h2A; ioreq = 1'b1; wr = 1'b1;
    tick();
    check("t6_first_commit", regs, 32'h2009_002A);
    rst = 1'b1;
    tick();
    check("t6_rst_regs", regs, 32'h0000_0000);
    check("t6_rst_locked", {28'd0, locked}, 32'd0);
    check("t6_rst_stb", {28'd0, wr_stb}, 32'd0);
    check("t6_rst_armed", {31'd0, dbg_armed}, 32'd1);
    rst = 1'b0;
    tick();
    check("t6_recommit_regs", regs, 32'h0000_002A);
    check("t6_recommit_stb", {28'd0, wr_stb}, 32'h1);
    stb_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      stb_cnt += $countones(wr_stb);
    end
    check("t6_single_commit", stb_cnt, 32'd0);
    ioreq = 1'b0; wr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
